// File: rtl/wb_svsg_scanner.sv
// wb_svsg_scanner: Wishbone classic master that steps a BCD digit into a seven-segment slave,
// reads back the decoded pattern and flags mismatches and bus timeouts.
module wb_svsg_scanner #(
  parameter logic [31:0] TARGET_ADDR = 32'h3000_0000,
  parameter logic [15:0] PERIOD = 16'd1000,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input logic clk,
  input logic reset,
  input logic enable,
  output logic wbm_cyc_o,
  output logic wbm_stb_o,
  output logic wbm_we_o,
  output logic [3:0] wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input logic wbm_ack_i,
  input logic [31:0] wbm_dat_i,
  output logic [3:0] digit,
  output logic check_ok,
  output logic mismatch,
  output logic timeout_err,
  output logic [7:0] err_count
);
  typedef enum logic [2:0] {IDLE, WR, SETTLE, RD, CHECK, WAIT} state_t;
  localparam logic [79:0] SEG = 80'hF6_FE_E0_BE_B6_66_F2_DA_60_FC;
  state_t state, state_nx;
  logic [7:0] tcnt;
  logic [15:0] wcnt;
  logic settled;
  logic [31:0] rdata;
  logic busy, tmo, match, err;
  assign busy = state == WR || state == RD;
  // an ack on the final allowed cycle wins over the timeout
  assign tmo = busy && !wbm_ack_i && tcnt == TIMEOUT - 8'd1;
  assign match = rdata == {24'h0, SEG[{digit, 3'b000} +: 8]};
  assign err = (state == CHECK && !match) || tmo;
  assign wbm_cyc_o = busy;
  assign wbm_stb_o = busy;
  assign wbm_we_o = state == WR;
  assign wbm_sel_o = busy ? 4'b0001 : 4'b0000;
  assign wbm_adr_o = busy ? TARGET_ADDR : 32'h0;
  assign wbm_dat_o = wbm_we_o ? {28'h0, digit} : 32'h0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = enable ? WR : IDLE;
      WR: state_nx = wbm_ack_i ? SETTLE : tmo ? WAIT : WR;
      SETTLE: state_nx = settled ? RD : SETTLE;
      RD: state_nx = wbm_ack_i ? CHECK : tmo ? WAIT : RD;
      CHECK: state_nx = WAIT;
      WAIT: state_nx = wcnt != 16'd0 ? WAIT : enable ? WR : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= 8'd0;
      wcnt <= 16'd0;
      settled <= 1'b0;
      rdata <= 32'h0;
      digit <= 4'd0;
      check_ok <= 1'b0;
      mismatch <= 1'b0;
      timeout_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state <= state_nx;
      tcnt <= state_nx != state ? 8'd0 : tcnt + 8'd1;
      wcnt <= state == WAIT ? wcnt - 16'd1 : PERIOD - 16'd1;
      settled <= state == SETTLE && !settled;
      if (state == RD && wbm_ack_i) rdata <= wbm_dat_i;
      check_ok <= state == CHECK && match;
      mismatch <= state == CHECK && !match;
      timeout_err <= tmo;
      // a failed write is retried with the same digit; a failed read moves on
      if (state == CHECK || (state == RD && tmo)) digit <= digit == 4'd9 ? 4'd0 : digit + 4'd1;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_wb_svsg_scanner.sv
// tb_wb_svsg_scanner: randomized scoreboard bench driving wb_svsg_scanner against a modelled seven-segment slave.
module tb_wb_svsg_scanner;
  localparam int TMO = 8;
  localparam int PER = 4;
  localparam logic [31:0] ADDR = 32'h3000_0000;
  typedef enum int {E_OK, E_BAD, E_TWR, E_TRD} ev_t;
  logic clk = 0, reset = 1, enable = 0;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0] wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic wbm_ack_i = 0;
  logic [31:0] wbm_dat_i = 0;
  logic [3:0] digit;
  logic check_ok, mismatch, timeout_err;
  logic [7:0] err_count;
  int n_chk = 0, n_fail = 0;
  int n_pulse = 0, n_ok = 0, n_bad = 0, n_tmo = 0;
  int p_lat_max = 0, p_drop_pct = 0, p_bad_pct = 0, p_bad_digit = -1, p_drop_wr_digit = -1;
  bit p_drop_rd = 0;
  ev_t q[$];
  int mdig = 0, merr = 0;
  string lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  wb_svsg_scanner #(.TARGET_ADDR(ADDR), .PERIOD(16'(PER)), .TIMEOUT(8'(TMO))) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .digit(digit), .check_ok(check_ok), .mismatch(mismatch), .timeout_err(timeout_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // segment a..g mapped to bits 7..1, dp on bit 0
  function automatic logic [7:0] seg(int d);
    string s;
    logic [7:0] p;
    s = lit[d];
    p = 8'h00;
    for (int i = 0; i < s.len(); i++) p |= 8'h80 >> (int'(s[i]) - 97);
    return p;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // slave: acks after a planned latency, latches written digit, returns decoded pattern
  int scnt = 0, cur_lat = 0;
  logic [3:0] sdig = 0;
  logic [31:0] cur_data = 0;
  always @(posedge clk) begin
    if (!wbm_cyc_o || wbm_ack_i) begin
      wbm_ack_i <= 0;
      scnt <= 0;
    end else begin
      if (scnt == 0) begin
        cur_lat = int'($urandom_range(p_lat_max, 0));
        if (int'($urandom_range(99, 0)) < p_drop_pct || (wbm_we_o && p_drop_wr_digit == int'(wbm_dat_o)) || (!wbm_we_o && p_drop_rd))
          cur_lat = 255;
        if (!wbm_we_o) begin
          cur_data = {24'h0, seg(int'(sdig))};
          if (p_bad_digit == int'(sdig)) cur_data = 32'h0;
          if (int'($urandom_range(99, 0)) < p_bad_pct) cur_data ^= 32'h1 << $urandom_range(31, 0);
          q.push_back(cur_lat > TMO - 2 ? E_TRD : cur_data == {24'h0, seg(mdig)} ? E_OK : E_BAD);
        end else if (cur_lat > TMO - 2) q.push_back(E_TWR);
      end
      scnt <= scnt + 1;
      if (scnt == cur_lat) begin
        wbm_ack_i <= 1;
        if (wbm_we_o) sdig <= wbm_dat_o[3:0];
        else wbm_dat_i <= cur_data;
      end
    end
  end

  // monitor: bus protocol checks and scoreboard pops on every result pulse
  int ncyc = 0, gk = 0, ek = 0;
  logic cyc_q = 0, ack_q = 0;
  ev_t e;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      mdig = 0;
      merr = 0;
      cyc_q = 0;
      ack_q = 0;
      ncyc = 0;
    end else begin
      if (wbm_cyc_o && !cyc_q) begin
        chk("bus stb/sel", 32'({wbm_stb_o, wbm_sel_o}), 32'h11);
        chk("bus adr", wbm_adr_o, ADDR);
        chk("bus dat", wbm_dat_o, wbm_we_o ? 32'(mdig) : 32'h0);
        ncyc = 0;
      end
      if (!wbm_cyc_o) chk("idle bus", 32'({wbm_stb_o, wbm_we_o, wbm_sel_o, |wbm_adr_o, |wbm_dat_o}), 32'h0);
      if (!wbm_cyc_o && cyc_q && !ack_q) chk("timeout length", 32'(ncyc), 32'(TMO));
      if (wbm_cyc_o) ncyc++;
      if (check_ok || mismatch || timeout_err) begin
        n_pulse++;
        if (check_ok) n_ok++;
        if (mismatch) n_bad++;
        if (timeout_err) n_tmo++;
        chk("pulse exclusive", 32'({1'b0, check_ok} + {1'b0, mismatch} + {1'b0, timeout_err}), 32'h1);
        chk("pulse expected", 32'(q.size() != 0), 32'h1);
        if (q.size() != 0) begin
          e = q.pop_front();
          gk = check_ok ? 0 : mismatch ? 1 : 2;
          ek = e == E_OK ? 0 : e == E_BAD ? 1 : 2;
          chk("pulse kind", 32'(gk), 32'(ek));
          if (e != E_TWR) mdig = (mdig + 1) % 10;
          if (e != E_OK && merr < 255) merr++;
          chk("digit", 32'(digit), 32'(mdig));
          chk("err_count", 32'(err_count), 32'(merr));
        end
      end
    end
    cyc_q = wbm_cyc_o;
    ack_q = wbm_ack_i && wbm_cyc_o;
  end

  task automatic wait_pulses(int n, int budget, string name);
    int target, c;
    target = n_pulse + n;
    c = 0;
    while (n_pulse < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(n_pulse >= target), 32'h1);
  endtask

  task automatic wait_bus(logic we, int budget, string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(wbm_cyc_o && wbm_we_o == we) && c < budget);
    chk(name, 32'(wbm_cyc_o && wbm_we_o == we), 32'h1);
  endtask

  task automatic chk_zero(string name);
    chk({name, " bus"}, 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'h0);
    chk({name, " adr"}, wbm_adr_o, 32'h0);
    chk({name, " dat"}, wbm_dat_o, 32'h0);
    chk({name, " digit"}, 32'(digit), 32'h0);
    chk({name, " pulses"}, 32'({check_ok, mismatch, timeout_err}), 32'h0);
    chk({name, " err_count"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    int base, c;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 0;
    enable = 1;
    base = n_ok;
    wait_pulses(10, 400, "t1 progress");
    chk("t1 check_ok count", 32'(n_ok - base), 32'd10);
    chk("t1 err_count", 32'(err_count), 32'h0);
    wait_bus(1'b1, 100, "t1 wrap write");
    chk("t1 wrap digit", wbm_dat_o, 32'h0);
    c = 0;
    while (!check_ok && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t1 check seen", 32'(check_ok), 32'h1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!wbm_cyc_o && c < 100);
    chk("wait length", 32'(c), 32'(PER));
    p_bad_digit = 3;
    base = n_bad;
    wait_pulses(10, 400, "t2 progress");
    p_bad_digit = -1;
    chk("t2 mismatch count", 32'(n_bad - base), 32'h1);
    chk("t2 err_count", 32'(err_count), 32'h1);
    p_drop_wr_digit = 5;
    base = n_tmo;
    c = 0;
    while (n_tmo == base && c < 500) begin
      @(negedge clk);
      c++;
    end
    p_drop_wr_digit = -1;
    chk("t3 timeout seen", 32'(n_tmo - base), 32'h1);
    wait_bus(1'b1, 100, "t3 retry write");
    chk("t3 retry digit", wbm_dat_o, 32'h5);
    p_lat_max = 7;
    p_drop_pct = 10;
    p_bad_pct = 25;
    wait_pulses(60, 3000, "random progress");
    p_lat_max = 0;
    p_drop_pct = 0;
    p_bad_pct = 0;
    p_drop_rd = 1;
    wait_pulses(260, 8000, "t4 progress");
    p_drop_rd = 0;
    chk("t4 saturated", 32'(err_count), 32'hFF);
    wait_bus(1'b0, 100, "t5 read");
    enable = 0;
    wait_pulses(1, 50, "t5 pulse");
    c = 0;
    repeat (40) begin
      @(negedge clk);
      if (wbm_cyc_o) c++;
    end
    chk("t5 bus idle", 32'(c), 32'h0);
    enable = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!wbm_cyc_o && c < 10);
    chk("t5 restart", 32'(c), 32'h1);
    p_drop_pct = 100;
    wait_bus(1'b1, 100, "t6 write");
    reset = 1;
    @(negedge clk);
    chk_zero("t6 reset");
    p_drop_pct = 0;
    @(negedge clk);
    reset = 0;
    base = n_ok;
    wait_pulses(3, 200, "t6 progress");
    chk("t6 check_ok count", 32'(n_ok - base), 32'h3);
    chk("t6 err_count", 32'(err_count), 32'h0);
    enable = 0;
    repeat (100) @(negedge clk);
    chk("queue drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
